dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU A / loader-debug B) arbiter in front of a single-ported data memory.
// Latency: grant is combinational in the request cycle; read data returns with rvalid one cycle later.
// Backpressure: a requester holds its fields until its gnt is high; B may lock the memory (b_lock), and the
//   optional starvation counter (`DMEM_ARB_STARVE_EN`, limit STARVE_LIMIT) forces a B grant after repeated A wins.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        nrst,
  // port A (CPU)
  input  logic        a_req,
  input  logic [3:0]  a_we,
  input  logic [9:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  // port B (loader / debug)
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [3:0]  b_we,
  input  logic [9:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  // memory side
  output logic [3:0]  dm_write,
  output logic [9:0]  data_addr,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    A_ACT    = 2'd1,
    B_ACT    = 2'd2,
    B_LOCKED = 2'd3
  } state_t;

  // A limit outside the 8-bit counter range can never be matched, so reject it at elaboration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  state_t state_q, state_d;
  logic   a_rvalid_q, a_rvalid_d;
  logic   b_rvalid_q, b_rvalid_d;
  logic   starve_force;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q == LIMIT8);

  // Count consecutive A wins while B waits; any B grant or an idle B clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_req || b_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (a_gnt) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grant decision: a lock hands the memory to B exclusively, otherwise A wins unless B is being starved.
  // Grants are held low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (nrst) begin
      if (state_q == B_LOCKED) begin
        b_gnt = b_req;
      end else if (a_req && !(b_req && starve_force)) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = b_req;
      end
    end
  end

  // Next state follows the grant just made; no grant (including a lock release) returns to IDLE.
  always_comb begin
    state_d    = IDLE;
    a_rvalid_d = a_gnt && (a_we == 4'd0);
    b_rvalid_d = b_gnt && (b_we == 4'd0);
    if (a_gnt) begin
      state_d = A_ACT;
    end else if (b_gnt) begin
      state_d = b_lock ? B_LOCKED : B_ACT;
    end
  end

  // FSM and read-return flags; reset drops any read still in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Memory-side mux: only the granted port drives the memory, and only in its grant cycle.
  always_comb begin
    dm_write  = 4'd0;
    data_addr = 10'd0;
    data_in   = 32'd0;
    if (a_gnt) begin
      dm_write  = a_we;
      data_addr = a_addr;
      data_in   = a_wdata;
    end else if (b_gnt) begin
      dm_write  = b_we;
      data_addr = b_addr;
      data_in   = b_wdata;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? data_out : 32'd0;
  assign b_rdata  = b_rvalid_q ? data_out : 32'd0;

endmodule
